ujump_dispatch_unit: RTL and testbench

- Parametrised, run-time patchable micro-jump dispatch table. It is the successor to the fixed combinational opcode-to-micro-PC decoder.
- It maps a fetched RISC-V instruction to the micro-code ROM entry address through a key built from opcode, funct3 and funct7[5].
- The lookup is registered behind a valid/ready handshake. At reset, an init FSM loads the table with the default decode map.
- A write port lets firmware or debug logic patch or disable individual entries. It sits between the instruction register and the micro-PC sequencer.

---
 rtl/ucode_pkg.sv | 66 ++++++
 rtl/ujump_table.sv | 28 ++
 rtl/ujump_dispatch_unit.sv | 124 ++++++++++++
 tb/tb_ujump_dispatch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// Shared micro-code constants: RV32 opcode fields, micro-PC entry addresses,
// the dispatch-table entry type and the key/default-map helpers.
package ucode_pkg;

    localparam int UC_ADDR_W = 8;

    // Opcode constants are inst[6:2]; inst[1:0] is always 2'b11 for RV32.
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [UC_ADDR_W-1:0] MICRO_PC_LUI_ADDR      = 8'h10;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_AUIPC_ADDR    = 8'h14;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_JAL_ADDR      = 8'h18;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_JALR_ADDR     = 8'h1C;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_BRANCH_ADDR   = 8'h20;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_LOAD_ADDR     = 8'h28;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_STORE_ADDR    = 8'h30;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_OP_IMM_ADDR   = 8'h38;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_OP_ADDR       = 8'h40;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_MISC_MEM_ADDR = 8'h48;
    localparam logic [UC_ADDR_W-1:0] MICRO_PC_SYSTEM_ADDR   = 8'h50;
    localparam logic [UC_ADDR_W-1:0] UNKNOWN_ADDR           = 8'hFF;

    typedef struct packed {
        logic                 enable;
        logic [UC_ADDR_W-1:0] target;
    } ujEntry_t;

    // The default map decodes opcode only, so funct3/funct7 variants of an
    // opcode all share one micro-routine until firmware patches them apart.
    function automatic ujEntry_t defaultEntry(input logic [8:0] key);
        ujEntry_t e;
        e.enable = 1'b1;
        e.target = UNKNOWN_ADDR;
        case (key[4:0])
            OPC_LUI:      e.target = MICRO_PC_LUI_ADDR;
            OPC_AUIPC:    e.target = MICRO_PC_AUIPC_ADDR;
            OPC_JAL:      e.target = MICRO_PC_JAL_ADDR;
            OPC_JALR:     e.target = MICRO_PC_JALR_ADDR;
            OPC_BRANCH:   e.target = MICRO_PC_BRANCH_ADDR;
            OPC_LOAD:     e.target = MICRO_PC_LOAD_ADDR;
            OPC_STORE:    e.target = MICRO_PC_STORE_ADDR;
            OPC_OP_IMM:   e.target = MICRO_PC_OP_IMM_ADDR;
            OPC_OP:       e.target = MICRO_PC_OP_ADDR;
            OPC_MISC_MEM: e.target = MICRO_PC_MISC_MEM_ADDR;
            OPC_SYSTEM:   e.target = MICRO_PC_SYSTEM_ADDR;
            default:      e.enable = 1'b0;
        endcase
        return e;
    endfunction

    // Full key {funct7[5], funct3, opcode[6:2]}; the top trims unused fields.
    function automatic logic [8:0] makeKey(input logic [31:0] inst);
        return {inst[30], inst[14:12], inst[6:2]};
    endfunction

endpackage

// File: rtl/ujump_table.sv
// Dispatch-table storage: flop array with one write port and one
// combinational read port that sees a same-cycle write (write-first).
module ujump_table #(
    parameter int KEY_W  = 9,
    parameter int DATA_W = 9,
    parameter int DEPTH  = 2**KEY_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [KEY_W-1:0]  wkey,
    input  logic [DATA_W-1:0] wdata,
    input  logic [KEY_W-1:0]  rkey,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the init FSM rewrites every entry, and a
    // reset term here would force a reset fan-out to all DEPTH entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wkey] <= wdata;
        end
    end

    assign rdata = (we && (wkey == rkey)) ? wdata : mem[rkey];

endmodule

// File: rtl/ujump_dispatch_unit.sv
// Patchable micro-jump dispatch: instruction key -> micro-code ROM address,
// registered behind valid/ready, with a reset-time table loader.
module ujump_dispatch_unit
    import ucode_pkg::*;
#(
    parameter int UADDR_W = UC_ADDR_W,
    parameter int USE_F3  = 1,
    parameter int USE_F7  = 1,
    parameter int KEY_W   = 5 + 3*USE_F3 + USE_F7,
    parameter int DEPTH   = 2**KEY_W
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [31:0]        inst,
    input  logic               instValid,
    output logic               instReady,
    output logic [UADDR_W-1:0] target,
    output logic               illegal,
    output logic               targetValid,
    input  logic               targetReady,
    input  logic               wrEn,
    input  logic [KEY_W-1:0]   wrKey,
    input  logic [UADDR_W-1:0] wrTarget,
    input  logic               wrEnable,
    output logic               wrReady,
    output logic               initDone
);

    localparam logic [0:0]         ST_INIT  = 1'b0;
    localparam logic [0:0]         ST_RUN   = 1'b1;
    localparam int                 ENT_W    = UADDR_W + 1;
    localparam logic [KEY_W:0]     LAST_IDX = (KEY_W+1)'(DEPTH - 1);
    localparam logic [UADDR_W-1:0] MISS     = UADDR_W'(UNKNOWN_ADDR);

    logic [0:0]       state;
    logic [KEY_W:0]   init_cnt;
    logic [8:0]       key_full;
    logic [KEY_W-1:0] rkey;
    logic             tbl_we;
    logic [KEY_W-1:0] tbl_wkey;
    logic [ENT_W-1:0] tbl_wdata;
    logic [ENT_W-1:0] tbl_rdata;
    ujEntry_t         dflt;
    logic             running;
    logic             accept;

    assign key_full = makeKey(inst);

    if (USE_F3 != 0 && USE_F7 != 0) begin : g_key_f3_f7
        assign rkey = key_full;
    end else if (USE_F3 != 0) begin : g_key_f3
        assign rkey = key_full[7:0];
    end else if (USE_F7 != 0) begin : g_key_f7
        assign rkey = {key_full[8], key_full[4:0]};
    end else begin : g_key_opc
        assign rkey = key_full[4:0];
    end

    assign running   = (state == ST_RUN);
    assign wrReady   = running;
    assign instReady = running && (!targetValid || targetReady);
    assign accept    = instValid && instReady;

    // The loader owns the write port during INIT; patches own it in RUN.
    always_comb begin
        // NOTE: every output of this block is assigned on all paths, so no latch.
        dflt = defaultEntry(9'(init_cnt[KEY_W-1:0]));
        if (running) begin
            tbl_we    = wrEn;
            tbl_wkey  = wrKey;
            tbl_wdata = {wrEnable, wrTarget};
        end else begin
            tbl_we    = 1'b1;
            tbl_wkey  = init_cnt[KEY_W-1:0];
            tbl_wdata = {dflt.enable, UADDR_W'(dflt.target)};
        end
    end

    ujump_table #(
        .KEY_W  (KEY_W),
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .wkey  (tbl_wkey),
        .wdata (tbl_wdata),
        .rkey  (rkey),
        .rdata (tbl_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            initDone <= 1'b0;
        end else begin
            initDone <= running;
            if (!running) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == LAST_IDX) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            targetValid <= 1'b0;
            target      <= MISS;
            illegal     <= 1'b0;
        end else if (accept) begin
            targetValid <= 1'b1;
            illegal     <= !tbl_rdata[UADDR_W];
            target      <= tbl_rdata[UADDR_W] ? tbl_rdata[UADDR_W-1:0] : MISS;
        end else if (targetReady) begin
            targetValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ujump_dispatch_unit.sv
// Directed bench for ujump_dispatch_unit: table-driven decode stream plus
// hand-written backpressure, patch and reset sequences.
module tb_ujump_dispatch_unit;

    localparam int KEY_W   = 9;
    localparam int DEPTH   = 512;
    localparam int UADDR_W = 8;

    logic               clk = 1'b0;
    logic               rstN;
    logic [31:0]        inst;
    logic               instValid;
    logic               instReady;
    logic [UADDR_W-1:0] target;
    logic               illegal;
    logic               targetValid;
    logic               targetReady;
    logic               wrEn;
    logic [KEY_W-1:0]   wrKey;
    logic [UADDR_W-1:0] wrTarget;
    logic               wrEnable;
    logic               wrReady;
    logic               initDone;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  exp_target;
        logic        exp_illegal;
        string       name;
    } vec_t;

    vec_t vecs [15];

    ujump_dispatch_unit dut (
        .clk         (clk),
        .rstN        (rstN),
        .inst        (inst),
        .instValid   (instValid),
        .instReady   (instReady),
        .target      (target),
        .illegal     (illegal),
        .targetValid (targetValid),
        .targetReady (targetReady),
        .wrEn        (wrEn),
        .wrKey       (wrKey),
        .wrTarget    (wrTarget),
        .wrEnable    (wrEnable),
        .wrReady     (wrReady),
        .initDone    (initDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [7:0] t, input logic ill);
        check({name, "_valid"}, {31'd0, targetValid}, 32'd1);
        check({name, "_target"}, {24'd0, target}, {24'd0, t});
        check({name, "_illegal"}, {31'd0, illegal}, {31'd0, ill});
    endtask

    // Counts cycles from the current point to initDone; flags any ready
    // asserted while the loader is still writing.
    task automatic wait_init(output int cycles, output logic leak);
        cycles = 0;
        leak   = instReady | wrReady;
        for (int c = 1; c <= DEPTH + 20; c++) begin
            tick();
            if (c < DEPTH && (instReady || wrReady)) leak = 1'b1;
            if (initDone) begin
                cycles = c;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        logic leak;

        vecs[0]  = '{32'h000002B7, 8'h10, 1'b0, "lui"};
        vecs[1]  = '{32'h00000097, 8'h14, 1'b0, "auipc"};
        vecs[2]  = '{32'h0000006F, 8'h18, 1'b0, "jal"};
        vecs[3]  = '{32'h00008067, 8'h1C, 1'b0, "jalr"};
        vecs[4]  = '{32'h0000007F, 8'hFF, 1'b1, "opc_7f"};
        vecs[5]  = '{32'h00000063, 8'h20, 1'b0, "beq"};
        vecs[6]  = '{32'h0000A083, 8'h28, 1'b0, "lw"};
        vecs[7]  = '{32'h0010A023, 8'h30, 1'b0, "sw"};
        vecs[8]  = '{32'h00100093, 8'h38, 1'b0, "addi"};
        vecs[9]  = '{32'h002081B3, 8'h40, 1'b0, "add"};
        vecs[10] = '{32'h402081B3, 8'h40, 1'b0, "sub"};
        vecs[11] = '{32'h0000000F, 8'h48, 1'b0, "fence"};
        vecs[12] = '{32'h00000073, 8'h50, 1'b0, "ecall"};
        vecs[13] = '{32'h0000000B, 8'hFF, 1'b1, "custom0"};
        vecs[14] = '{32'h000002B4, 8'h10, 1'b0, "lui_lowbits"};

        rstN = 1'b0; inst = '0; instValid = 1'b0; targetReady = 1'b0;
        wrEn = 1'b0; wrKey = '0; wrTarget = '0; wrEnable = 1'b0;
        tick();
        tick();
        check("rst_valid",     {31'd0, targetValid}, 32'd0);
        check("rst_target",    {24'd0, target},      32'h0000_00FF);
        check("rst_illegal",   {31'd0, illegal},     32'd0);
        check("rst_instready", {31'd0, instReady},   32'd0);
        check("rst_wrready",   {31'd0, wrReady},     32'd0);
        check("rst_initdone",  {31'd0, initDone},    32'd0);

        rstN = 1'b1;
        wait_init(cyc, leak);
        check("init_cycles", cyc, DEPTH + 1);
        check("init_ready_leak", {31'd0, leak}, 32'd0);

        // Back-to-back stream: one new target per cycle, in order.
        targetReady = 1'b1;
        for (int i = 0; i < 15; i++) begin
            inst = vecs[i].inst;
            instValid = 1'b1;
            #1;
            check({vecs[i].name, "_instready"}, {31'd0, instReady}, 32'd1);
            tick();
            check_out(vecs[i].name, vecs[i].exp_target, vecs[i].exp_illegal);
        end
        instValid = 1'b0;
        tick();
        check("drain_valid", {31'd0, targetValid}, 32'd0);

        // Backpressure: ADDI held for 3 cycles while LUI waits.
        inst = 32'h00100093; instValid = 1'b1;
        tick();
        check_out("bp_first", 8'h38, 1'b0);
        targetReady = 1'b0;
        inst = 32'h000002B7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_instready", {31'd0, instReady}, 32'd0);
            tick();
            check_out("bp_hold", 8'h38, 1'b0);
        end
        targetReady = 1'b1;
        #1;
        check("bp_resume_ready", {31'd0, instReady}, 32'd1);
        tick();
        check_out("bp_lui", 8'h10, 1'b0);
        inst = 32'h0000006F;
        tick();
        check_out("bp_jal", 8'h18, 1'b0);
        instValid = 1'b0;
        tick();
        check("bp_drain", {31'd0, targetValid}, 32'd0);

        // Patch ADD (key 0x00C) while looking it up in the same cycle.
        inst = 32'h002081B3; instValid = 1'b1;
        wrEn = 1'b1; wrKey = 9'h00C; wrTarget = 8'h5A; wrEnable = 1'b1;
        #1;
        check("patch_wrready", {31'd0, wrReady}, 32'd1);
        tick();
        check_out("patch_bypass", 8'h5A, 1'b0);
        wrEn = 1'b0;
        tick();
        check_out("patch_stored", 8'h5A, 1'b0);
        inst = 32'h402081B3;
        tick();
        check_out("patch_sub_untouched", 8'h40, 1'b0);
        inst = 32'h002081B3;
        tick();
        check_out("reg_before_patch", 8'h5A, 1'b0);
        targetReady = 1'b0; instValid = 1'b0;
        wrEn = 1'b1; wrKey = 9'h00C; wrTarget = 8'h33; wrEnable = 1'b1;
        tick();
        wrEn = 1'b0;
        check_out("reg_unchanged_by_patch", 8'h5A, 1'b0);
        targetReady = 1'b1;
        tick();
        instValid = 1'b1;
        tick();
        check_out("patch_second", 8'h33, 1'b0);
        instValid = 1'b0;
        tick();

        // Disable BRANCH (key 0x018).
        wrEn = 1'b1; wrKey = 9'h018; wrTarget = 8'h20; wrEnable = 1'b0;
        tick();
        wrEn = 1'b0;
        inst = 32'h00000063; instValid = 1'b1;
        tick();
        check_out("branch_disabled", 8'hFF, 1'b1);

        // Reset mid-RUN with a pending target, then again mid-INIT.
        targetReady = 1'b0;
        tick();
        #2;
        rstN = 1'b0;
        #1;
        check("midrun_rst_valid",    {31'd0, targetValid}, 32'd0);
        check("midrun_rst_target",   {24'd0, target},      32'h0000_00FF);
        check("midrun_rst_illegal",  {31'd0, illegal},     32'd0);
        check("midrun_rst_initdone", {31'd0, initDone},    32'd0);
        instValid = 1'b0;
        tick();
        rstN = 1'b1;
        repeat (100) tick();
        check("midinit_ready", {31'd0, instReady}, 32'd0);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        wait_init(cyc, leak);
        check("reinit_cycles", cyc, DEPTH + 1);
        check("reinit_ready_leak", {31'd0, leak}, 32'd0);

        targetReady = 1'b1;
        inst = 32'h00000063; instValid = 1'b1;
        tick();
        check_out("branch_restored", 8'h20, 1'b0);
        inst = 32'h002081B3;
        tick();
        check_out("add_restored", 8'h40, 1'b0);
        instValid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
